// File: rtl/hdlc_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_deframer_if
// Desc     : Serial line input and octet/status output bundle of the HDLC RX deframer.
// Revision : 1.0
// ============================================================================
interface hdlc_rx_deframer_if;
  logic       rxen_i;
  logic       rx_i;
  logic [7:0] rxd_o;
  logic       rxd_valid_o;
  logic       sof_o;
  logic       eof_o;
  logic       err_align_o;
  logic       err_short_o;
  logic       fcs_ok_o;
  logic       abort_o;

  // master: the line source / octet consumer side
  modport master (
    output rxen_i, rx_i,
    input  rxd_o, rxd_valid_o, sof_o, eof_o, err_align_o, err_short_o, fcs_ok_o, abort_o
  );

  // slave: the deframer itself
  modport slave (
    input  rxen_i, rx_i,
    output rxd_o, rxd_valid_o, sof_o, eof_o, err_align_o, err_short_o, fcs_ok_o, abort_o
  );
endinterface
`default_nettype wire

// File: rtl/hdlc_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_deframer
// Desc     : HDLC receive deframer: flag hunt, zero destuffing, LSB-first octet
//            assembly with a one-octet hold, frame status. Define HDLC_RX_FCS_EN
//            to enable the CRC-16/X.25 residue check behind fcs_ok_o.
// Revision : 1.0
// ============================================================================
module hdlc_rx_deframer #(
  parameter int unsigned MIN_BYTES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hdlc_rx_deframer_if.slave  rx_if
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_OPEN = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [8:0] c_min_bytes = 9'(MIN_BYTES);

`ifdef HDLC_RX_FCS_EN
  localparam logic [15:0] c_crc_init = 16'hFFFF;
  localparam logic [15:0] c_crc_good = 16'hF0B8;

  // Line-order (LSB first) bitwise update; equivalent to updating per destuffed bit.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [15:0] r_crc, w_crc_n;
`endif

  state_t     r_state, w_state_n;
  logic [2:0] r_ones, w_ones_n;
  logic [2:0] r_bitcnt, w_bitcnt_n;
  logic [6:0] r_shift, w_shift_n;
  logic [7:0] r_held, w_held_n;
  logic       r_held_vld, w_held_vld_n;
  logic [7:0] r_bytes, w_bytes_n;

  logic [7:0] r_rxd, w_rxd_n;
  logic       r_valid, w_valid_n;
  logic       r_sof, w_sof_n;
  logic       r_eof, w_eof_n;
  logic       r_align, w_align_n;
  logic       r_short, w_short_n;
  logic       r_fcs_ok, w_fcs_ok_n;
  logic       r_abort, w_abort_n;

  logic       w_bit;
  logic       w_flag;
  logic       w_abort;
  logic       w_shift_bit;
  logic [7:0] w_octet;
  logic [7:0] w_bytes_inc;
  logic       w_first;
  logic       w_short;
  logic       w_fcs_ok;

  assign w_bit = rx_if.rx_i;
  // Six ones then a zero closes a flag; a sixth one is never data, a zero after five is stuffing.
  assign w_flag      = rx_if.rxen_i & ~w_bit & (r_ones == 3'd6);
  assign w_abort     = rx_if.rxen_i &  w_bit & (r_ones == 3'd6);
  assign w_shift_bit = rx_if.rxen_i &
                       (w_bit ? (r_ones < 3'd5) : ((r_ones != 3'd5) && (r_ones != 3'd6)));
  assign w_octet     = {w_bit, r_shift};
  assign w_bytes_inc = (r_bytes == 8'hFF) ? r_bytes : r_bytes + 8'd1;
  assign w_first     = (r_bytes == 8'd0);
  assign w_short     = ({1'b0, r_bytes} + 9'd1) < c_min_bytes;

`ifdef HDLC_RX_FCS_EN
  assign w_fcs_ok = (r_crc == c_crc_good);
`else
  assign w_fcs_ok = 1'b1;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_ones_n     = r_ones;
    w_bitcnt_n   = r_bitcnt;
    w_shift_n    = r_shift;
    w_held_n     = r_held;
    w_held_vld_n = r_held_vld;
    w_bytes_n    = r_bytes;
    w_rxd_n      = r_rxd;
    w_valid_n    = 1'b0;
    w_sof_n      = 1'b0;
    w_eof_n      = 1'b0;
    w_align_n    = 1'b0;
    w_short_n    = 1'b0;
    w_fcs_ok_n   = 1'b0;
    w_abort_n    = 1'b0;
`ifdef HDLC_RX_FCS_EN
    w_crc_n      = r_crc;
`endif

    if (rx_if.rxen_i) begin
      w_ones_n = w_bit ? ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1) : 3'd0;

      case (r_state)
        ST_HUNT: begin
          if (w_flag) w_state_n = ST_OPEN;
        end
        ST_OPEN, ST_DATA: begin
          if (w_abort) begin
            w_state_n    = ST_HUNT;
            w_held_vld_n = 1'b0;
            w_abort_n    = (r_state == ST_DATA);
          end else if (w_flag) begin
            // Flags seen while still OPEN are idle fill and produce nothing.
            if (r_state == ST_DATA) begin
              w_rxd_n    = r_held_vld ? r_held : 8'h00;
              w_valid_n  = 1'b1;
              w_eof_n    = 1'b1;
              w_sof_n    = w_first;
              w_align_n  = ~r_held_vld | (r_bitcnt != 3'd6);
              w_short_n  = w_short;
              w_fcs_ok_n = w_fcs_ok;
            end
            w_state_n = ST_OPEN;
          end else if (w_shift_bit) begin
            w_shift_n  = {w_bit, r_shift[6:1]};
            w_bitcnt_n = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (r_held_vld) begin
                w_rxd_n   = r_held;
                w_valid_n = 1'b1;
                w_sof_n   = w_first;
                w_bytes_n = w_bytes_inc;
              end
              w_held_n     = w_octet;
              w_held_vld_n = 1'b1;
              w_state_n    = ST_DATA;
`ifdef HDLC_RX_FCS_EN
              w_crc_n      = crc_byte(r_crc, w_octet);
`endif
            end
          end
        end
        default: w_state_n = ST_HUNT;
      endcase

      // Every flag starts a fresh frame context, whichever state it was found in.
      if (w_flag) begin
        w_bitcnt_n   = 3'd0;
        w_bytes_n    = 8'd0;
        w_held_vld_n = 1'b0;
`ifdef HDLC_RX_FCS_EN
        w_crc_n      = c_crc_init;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_HUNT;
      r_ones     <= 3'd0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 7'd0;
      r_held     <= 8'd0;
      r_held_vld <= 1'b0;
      r_bytes    <= 8'd0;
      r_rxd      <= 8'd0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_align    <= 1'b0;
      r_short    <= 1'b0;
      r_fcs_ok   <= 1'b0;
      r_abort    <= 1'b0;
`ifdef HDLC_RX_FCS_EN
      r_crc      <= c_crc_init;
`endif
    end else begin
      r_state    <= w_state_n;
      r_ones     <= w_ones_n;
      r_bitcnt   <= w_bitcnt_n;
      r_shift    <= w_shift_n;
      r_held     <= w_held_n;
      r_held_vld <= w_held_vld_n;
      r_bytes    <= w_bytes_n;
      r_rxd      <= w_rxd_n;
      r_valid    <= w_valid_n;
      r_sof      <= w_sof_n;
      r_eof      <= w_eof_n;
      r_align    <= w_align_n;
      r_short    <= w_short_n;
      r_fcs_ok   <= w_fcs_ok_n;
      r_abort    <= w_abort_n;
`ifdef HDLC_RX_FCS_EN
      r_crc      <= w_crc_n;
`endif
    end
  end

  assign rx_if.rxd_o       = r_rxd;
  assign rx_if.rxd_valid_o = r_valid;
  assign rx_if.sof_o       = r_sof;
  assign rx_if.eof_o       = r_eof;
  assign rx_if.err_align_o = r_align;
  assign rx_if.err_short_o = r_short;
  assign rx_if.fcs_ok_o    = r_fcs_ok;
  assign rx_if.abort_o     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_rx_deframer
// Desc     : Directed frames with a queued scoreboard for hdlc_rx_deframer.
// Revision : 1.0
// ============================================================================
module tb_hdlc_rx_deframer;

  localparam int MIN_B = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       align;
    logic       shrt;
    logic       fcs;
  } exp_t;

  logic clk;
  logic rst_n;

  hdlc_rx_deframer_if u_if ();

  hdlc_rx_deframer #(.MIN_BYTES(MIN_B)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .rx_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  logic [7:0] fr[$];
  int         n_checks   = 0;
  int         n_errors   = 0;
  int         exp_aborts = 0;
  int         tx_ones    = 0;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    u_if.rx_i   = b;
    u_if.rxen_i = 1'b1;
    @(negedge clk);
    u_if.rxen_i = 1'b0;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_octet(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      tx_ones = d[i] ? tx_ones + 1 : 0;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end
  endtask

  // Expected octets for the frame currently in fr; status only on the last one.
  task automatic push_frame(input logic align);
    logic [15:0] crc;
    logic        ok;
    exp_t        e;
    crc = 16'hFFFF;
    foreach (fr[i]) crc = crc_upd(crc, fr[i]);
`ifdef HDLC_RX_FCS_EN
    ok = (crc == 16'hF0B8);
`else
    ok = 1'b1;
`endif
    foreach (fr[i]) begin
      e.d     = fr[i];
      e.sof   = (i == 0);
      e.eof   = (i == fr.size() - 1);
      e.align = e.eof & align;
      e.shrt  = e.eof & (fr.size() < MIN_B);
      e.fcs   = e.eof & ok;
      sb.push_back(e);
    end
  endtask

  task automatic push_one(input logic [7:0] d, input logic sof);
    exp_t e;
    e = '{d: d, sof: sof, eof: 1'b0, align: 1'b0, shrt: 1'b0, fcs: 1'b0};
    sb.push_back(e);
  endtask

  task automatic send_frame();
    push_frame(1'b0);
    foreach (fr[i]) send_octet(fr[i]);
    send_flag();
  endtask

  task automatic check_idle(input string name);
    logic [14:0] got;
    got = {u_if.rxd_o, u_if.rxd_valid_o, u_if.sof_o, u_if.eof_o, u_if.err_align_o,
           u_if.err_short_o, u_if.fcs_ok_o, u_if.abort_o};
    n_checks++;
    if (got != 15'd0) begin
      n_errors++;
      $display("FAIL %s: outputs=%04h, expected 0000", name, got);
    end
  endtask

  // Monitor: every presented octet and abort pulse is matched against the queues.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst_n && u_if.rxd_valid_o) begin
      got = '{d: u_if.rxd_o, sof: u_if.sof_o, eof: u_if.eof_o, align: u_if.err_align_o,
              shrt: u_if.err_short_o, fcs: u_if.fcs_ok_o};
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_octet: got d=%02h sof=%b eof=%b, expected no output",
                 got.d, got.sof, got.eof);
      end else begin
        e = sb.pop_front();
        if (got != e) begin
          n_errors++;
          $display("FAIL octet: got d=%02h sof=%b eof=%b align=%b short=%b fcs=%b, expected d=%02h sof=%b eof=%b align=%b short=%b fcs=%b",
                   got.d, got.sof, got.eof, got.align, got.shrt, got.fcs,
                   e.d, e.sof, e.eof, e.align, e.shrt, e.fcs);
        end
      end
    end
    if (rst_n && u_if.abort_o) begin
      n_checks++;
      if (exp_aborts == 0) begin
        n_errors++;
        $display("FAIL abort: got abort pulse, expected none");
      end else begin
        exp_aborts--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] crc;
    logic [15:0] fcs;
    rst_n       = 1'b0;
    u_if.rxen_i = 1'b0;
    u_if.rx_i   = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: frame with a correct FCS, FF forces stuffing
    fr = '{8'hFF, 8'h03, 8'hC0, 8'h21};
    crc = 16'hFFFF;
    foreach (fr[i]) crc = crc_upd(crc, fr[i]);
    fcs = ~crc;
    fr.push_back(fcs[7:0]);
    fr.push_back(fcs[15:8]);
    send_flag();
    send_frame();

    // 2: idle flags, then a frame with stuffed zeros in 7C and 3F
    repeat (4) send_flag();
    fr = '{8'h7C, 8'h3F, 8'h00, 8'h00};
    send_frame();

    // 3: abort mid-frame, then a clean frame
    push_one(8'h12, 1'b1);
    exp_aborts++;
    send_octet(8'h12);
    send_octet(8'h34);
    repeat (8) send_bit(1'b1);
    send_flag();
    fr = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_frame();

    // 4: single-octet frame is short
    fr = '{8'hAA};
    send_frame();

    // 5: three stray bits before the flag complete an 0xF0 octet out of the flag prefix
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hF0};
    push_frame(1'b1);
    send_octet(8'h11);
    send_octet(8'h22);
    send_octet(8'h33);
    send_octet(8'h44);
    repeat (3) send_bit(1'b0);
    send_flag();

    // 6: reset during the second of two frames
    fr = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_frame();
    push_one(8'hB1, 1'b1);
    push_one(8'hB2, 1'b0);
    send_octet(8'hB1);
    send_octet(8'hB2);
    send_octet(8'hB3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    send_octet(8'hB4);
    send_octet(8'hB5);
    send_flag();
    fr = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_frame();

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL missing_octets: %0d still queued, expected 0", sb.size());
    end
    n_checks++;
    if (exp_aborts != 0) begin
      n_errors++;
      $display("FAIL missing_abort: %0d abort pulses outstanding, expected 0", exp_aborts);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
